q88_dot_accum: RTL and testbench
================================

Name: q88_dot_accum

Overview:
- Downstream consumer of the registered signed Q8.8 multiplier output.
- Accumulates a fixed-length group of N_TERMS Q8.8 products into a wide signed accumulator and saturates the sum back to Q8.8.
- Presents the result on a valid/ready output handshake.
- Forms the reduction half of a dot-product / FIR tap-sum datapath.

Parameters:
- N_TERMS, 8, number of products summed per result (>= 2).
- ACC_W, 24, accumulator width in bits, Q(ACC_W-8).8; must satisfy ACC_W >= 16 + clog2(N_TERMS).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous active-high reset.
- CLR  input  1  synchronous abort: discards partial sum and any pending result.
- IN_DATA  input  16  signed Q8.8 product term.
- IN_VALID  input  1  IN_DATA valid this cycle.
- IN_READY  output  1  block accepts a term this cycle.
- OUT_DATA  output  16  signed Q8.8 saturated group sum.
- OUT_SAT  output  1  result was clipped; qualified by OUT_VALID.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  downstream accepts result.

Behaviour:
- Clocking and reset: one clock (CLK); reset is synchronous and active-high (RST).
- RST high: state=ACCUM, acc=0, cnt=0, OUT_DATA=0x0000, OUT_SAT=0, OUT_VALID=0. IN_READY=0 while RST is high.
- Accept condition: a term is accepted when IN_VALID & IN_READY at a rising edge.
- State ACCUM:
  - IN_READY=1.
  - On accept with cnt < N_TERMS-1: acc <= acc + sign_extend(IN_DATA); cnt <= cnt+1.
  - IN_VALID gaps are allowed; acc and cnt hold.
- ACCUM -> DONE: on accept with cnt == N_TERMS-1, with s = acc + sign_extend(IN_DATA):
  - OUT_DATA <= sat(s); OUT_SAT <= (s outside range); OUT_VALID <= 1.
  - acc <= 0; cnt <= 0; state <= DONE.
- Latency: OUT_VALID rises on the first edge after the final term is accepted. Minimum period is N_TERMS+1 cycles per result.
- State DONE:
  - IN_READY=0; IN_VALID is ignored and no term is consumed.
  - OUT_DATA, OUT_SAT and OUT_VALID hold stable while OUT_READY=0.
  - On OUT_VALID & OUT_READY: OUT_VALID <= 0, state <= ACCUM. The first term of the next group can be accepted the following cycle.
- sat(s):
  - s > 32767 -> 0x7FFF.
  - s < -32768 -> 0x8000.
  - Otherwise s[15:0].
  - No rounding; the binary point is unchanged (Q8.8 in, Q8.8 out).
- Accumulator overflow cannot occur, given the ACC_W constraint.
- CLR high:
  - Same effect as RST on acc, cnt, state, OUT_VALID and OUT_SAT. OUT_DATA holds its value.
  - A term presented in the same cycle is dropped.
  - IN_READY follows the state normally.
- Priority: RST > CLR > output handshake > input accept.
- Reset or CLR mid-group or during DONE loses the partial sum or pending result; no residue carries into the next group.
- IN_READY is decoded combinationally from state and RST only; there is no combinational path from OUT_READY or IN_VALID.

Decomposition:
- Shared package/include q88_pkg:
  - Q_W=16, Q_FRAC=8.
  - Q_MAX=16'sh7FFF, Q_MIN=16'sh8000.
  - State encodings ST_ACCUM=1'b0, ST_DONE=1'b1.
  - clog2 function.
- Sub-module q88_sat: combinational, parameter IN_W. Takes a signed IN_W-bit input and produces 16-bit saturated out plus a sat flag. Reusable by other Q8.8 stages.
- Counter, FSM and accumulator stay in q88_dot_accum.

Test Plan:
- Unity sum (defaults): 8 terms of 0x0100 back-to-back, OUT_READY=1 -> OUT_DATA=0x0800, OUT_SAT=0, OUT_VALID one cycle after the 8th accept, high for exactly 1 cycle.
- Saturation both signs:
  - 8 x 0x7FFF -> 0x7FFF, OUT_SAT=1.
  - Then 8 x 0x8000 -> 0x8000, OUT_SAT=1.
- Mixed signs with gaps: 4 x 0x0180 (1.5) and 4 x 0xFF00 (-1.0), interleaved with random IN_VALID low cycles -> OUT_DATA=0x0200, OUT_SAT=0.
- Backpressure: complete a group with OUT_READY=0 for 6 cycles and IN_VALID=1 throughout.
  - OUT_DATA/OUT_VALID stable, IN_READY=0, no terms consumed.
  - After a 1-cycle OUT_READY pulse, the next 8 x 0x0080 -> 0x0400.
- Abort: 3 terms of 0x1000, then CLR for 1 cycle with IN_VALID=1 and 0x1000, then 8 x 0x0040 -> 0x0200 (no residue, dropped term not counted).
  - Repeat with RST instead of CLR, asserted while in DONE -> OUT_VALID falls on the next edge, and OUT_DATA=0x0000.
- Parameter sweep: N_TERMS=2, ACC_W=17. Inputs 0x7FFF + 0x0001 -> 0x7FFF, OUT_SAT=1. Then 0xC000 + 0xC000 -> 0x8000, OUT_SAT=0 (exact minimum, not clipped).

Source files
------------

// File: rtl/q88_pkg.sv
// Shared Q8.8 definitions: format widths, saturation limits, FSM encodings and helpers.
package q88_pkg;

   localparam int unsigned Q_W    = 16;
   localparam int unsigned Q_FRAC = 8;

   localparam logic signed [Q_W-1:0] Q_MAX = 16'sh7FFF;
   localparam logic signed [Q_W-1:0] Q_MIN = 16'sh8000;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   // Ceiling log2 for elaboration-time width sizing.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/q88_sat.sv
// Combinational clip of a wide signed Q.8 value into Q8.8, flagging when clipping occurred.
module q88_sat
   import q88_pkg::*;
#(
   parameter int unsigned IN_W = 24
) (
   input  logic signed [IN_W-1:0] val,
   output logic        [Q_W-1:0]  sat_val_c,
   output logic                   clip_c
);

   // Limits widened to the input width; IN_W must be at least Q_W.
   localparam logic signed [IN_W-1:0] HI = IN_W'(Q_MAX);
   localparam logic signed [IN_W-1:0] LO = IN_W'(Q_MIN);

   always_comb begin
      sat_val_c = val[Q_W-1:0];
      clip_c    = 1'b0;
      if (val > HI) begin
         sat_val_c = Q_MAX;
         clip_c    = 1'b1;
      end else if (val < LO) begin
         sat_val_c = Q_MIN;
         clip_c    = 1'b1;
      end
   end

endmodule

// File: rtl/q88_dot_accum.sv
// Sums groups of N_TERMS signed Q8.8 products in a wide accumulator and emits the
// saturated Q8.8 result on a valid/ready output.
module q88_dot_accum
   import q88_pkg::*;
#(
   parameter int unsigned N_TERMS = 8,
   parameter int unsigned ACC_W   = 24
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           CLR,
   input  logic [Q_W-1:0] IN_DATA,
   input  logic           IN_VALID,
   output logic           IN_READY,
   output logic [Q_W-1:0] OUT_DATA,
   output logic           OUT_SAT,
   output logic           OUT_VALID,
   input  logic           OUT_READY
);

   localparam int unsigned CNT_W = (clog2(N_TERMS) > 0) ? clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic        [CNT_W-1:0]   cnt_q, cnt_d;
   logic        [Q_W-1:0]     data_d;
   logic                      sat_d;
   logic                      valid_d;

   logic signed [ACC_W-1:0]   sum_c;
   logic        [Q_W-1:0]     sat_val_c;
   logic                      clip_c;

   // Ready depends only on state and reset, never on the handshake inputs.
   assign IN_READY = (state_q == ST_ACCUM) && !RST;

   assign sum_c = acc_q + ACC_W'($signed(IN_DATA));

   q88_sat #(
      .IN_W (ACC_W)
   ) u_sat (
      .val       (sum_c),
      .sat_val_c (sat_val_c),
      .clip_c    (clip_c)
   );

   // Next-state: CLR beats the output handshake, which beats input accept.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      data_d  = OUT_DATA;
      sat_d   = OUT_SAT;
      valid_d = OUT_VALID;

      if (CLR) begin
         state_d = ST_ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         sat_d   = 1'b0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (IN_VALID) begin
                  if (cnt_q == LAST) begin
                     data_d  = sat_val_c;
                     sat_d   = clip_c;
                     valid_d = 1'b1;
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = ST_DONE;
                  end else begin
                     acc_d = sum_c;
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (OUT_READY) begin
                  valid_d = 1'b0;
                  state_d = ST_ACCUM;
               end
            end
            default: state_d = ST_ACCUM;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         OUT_DATA  <= '0;
         OUT_SAT   <= 1'b0;
         OUT_VALID <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         OUT_DATA  <= data_d;
         OUT_SAT   <= sat_d;
         OUT_VALID <= valid_d;
      end
   end

endmodule

// File: tb/tb_q88_dot_accum.sv
// Directed and randomized checks of q88_dot_accum against an integer-sum reference,
// with a second instance at N_TERMS=2, ACC_W=17.
module tb_q88_dot_accum;

   logic        CLK = 1'b0;
   logic        RST, CLR, IN_VALID, OUT_READY;
   logic [15:0] IN_DATA;
   logic        IN_READY, OUT_SAT, OUT_VALID;
   logic [15:0] OUT_DATA;

   logic        rst2, clr2, in_valid2, out_ready2;
   logic [15:0] in_data2;
   logic        in_ready2, out_sat2, out_valid2;
   logic [15:0] out_data2;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] grp[$];

   always #5 CLK = ~CLK;

   q88_dot_accum u_dut (
      .CLK       (CLK),
      .RST       (RST),
      .CLR       (CLR),
      .IN_DATA   (IN_DATA),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .OUT_DATA  (OUT_DATA),
      .OUT_SAT   (OUT_SAT),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY)
   );

   q88_dot_accum #(
      .N_TERMS (2),
      .ACC_W   (17)
   ) u_dut2 (
      .CLK       (CLK),
      .RST       (rst2),
      .CLR       (clr2),
      .IN_DATA   (in_data2),
      .IN_VALID  (in_valid2),
      .IN_READY  (in_ready2),
      .OUT_DATA  (out_data2),
      .OUT_SAT   (out_sat2),
      .OUT_VALID (out_valid2),
      .OUT_READY (out_ready2)
   );

   // Reference: exact integer sum clipped to the Q8.8 range; returns {sat, data}.
   function automatic logic [16:0] model(input int s);
      if (s > 32767)  return {1'b1, 16'h7FFF};
      if (s < -32768) return {1'b1, 16'h8000};
      return {1'b0, 16'(s)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic feed(input logic [15:0] t, input int max_gap);
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
         IN_VALID = 1'b0;
         IN_DATA  = 16'($urandom);
         tick();
      end
      IN_VALID = 1'b1;
      IN_DATA  = t;
      chk("in_ready_accum", 32'(IN_READY), 32'd1);
      tick();
      IN_VALID = 1'b0;
   endtask

   // Feeds grp, checks the result one edge after the last accept, then drains it.
   task automatic run_group(input int max_gap, input int hold);
      int          s;
      logic [16:0] e;
      s = 0;
      foreach (grp[i]) s += int'($signed(grp[i]));
      e = model(s);
      OUT_READY = (hold == 0);
      foreach (grp[i]) feed(grp[i], max_gap);
      chk("out_valid_rise", 32'(OUT_VALID), 32'd1);
      chk("out_data", 32'(OUT_DATA), 32'(e[15:0]));
      chk("out_sat", 32'(OUT_SAT), 32'(e[16]));
      if (hold > 0) begin
         repeat (hold) begin
            IN_VALID = 1'b1;
            IN_DATA  = 16'h1234;
            tick();
            chk("bp_in_ready", 32'(IN_READY), 32'd0);
            chk("bp_valid_hold", 32'(OUT_VALID), 32'd1);
            chk("bp_data_hold", 32'(OUT_DATA), 32'(e[15:0]));
         end
         OUT_READY = 1'b1;
         tick();
         OUT_READY = 1'b0;
         IN_VALID  = 1'b0;
         chk("bp_release", 32'(OUT_VALID), 32'd0);
      end else begin
         tick();
         chk("out_valid_one_cycle", 32'(OUT_VALID), 32'd0);
      end
      grp.delete();
   endtask

   task automatic feed2(input logic [15:0] t);
      in_valid2 = 1'b1;
      in_data2  = t;
      chk("n2_in_ready", 32'(in_ready2), 32'd1);
      tick();
      in_valid2 = 1'b0;
   endtask

   task automatic run2(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] e;
      e = model(int'($signed(a)) + int'($signed(b)));
      out_ready2 = 1'b1;
      feed2(a);
      feed2(b);
      chk("n2_valid", 32'(out_valid2), 32'd1);
      chk("n2_data", 32'(out_data2), 32'(e[15:0]));
      chk("n2_sat", 32'(out_sat2), 32'(e[16]));
      tick();
      chk("n2_valid_fall", 32'(out_valid2), 32'd0);
   endtask

   initial begin
      RST = 1'b1; CLR = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b1;
      rst2 = 1'b1; clr2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
      repeat (3) tick();
      chk("rst_in_ready", 32'(IN_READY), 32'd0);
      chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_out_data", 32'(OUT_DATA), 32'h0);
      chk("rst_out_sat", 32'(OUT_SAT), 32'd0);
      RST = 1'b0;
      rst2 = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(IN_READY), 32'd1);

      // Unity sum
      repeat (8) grp.push_back(16'h0100);
      run_group(0, 0);

      // Saturation, both signs
      repeat (8) grp.push_back(16'h7FFF);
      run_group(0, 0);
      repeat (8) grp.push_back(16'h8000);
      run_group(0, 0);

      // Mixed signs with random input gaps
      for (int i = 0; i < 4; i++) begin
         grp.push_back(16'h0180);
         grp.push_back(16'hFF00);
      end
      run_group(3, 0);

      // Backpressure, then a clean group
      repeat (8) grp.push_back(16'($urandom_range(16'h0200, 0)));
      run_group(0, 6);
      repeat (8) grp.push_back(16'h0080);
      run_group(0, 0);

      // Random groups with gaps and random output stalls
      for (int g = 0; g < 6; g++) begin
         repeat (8) grp.push_back(16'($urandom));
         run_group(2, int'($urandom_range(3, 0)));
      end

      // CLR mid-group drops the partial sum and the coincident term
      OUT_READY = 1'b1;
      repeat (3) feed(16'h1000, 0);
      CLR = 1'b1; IN_VALID = 1'b1; IN_DATA = 16'h1000;
      #1;
      chk("clr_in_ready_follows_state", 32'(IN_READY), 32'd1);
      tick();
      CLR = 1'b0; IN_VALID = 1'b0;
      chk("clr_valid", 32'(OUT_VALID), 32'd0);
      repeat (8) grp.push_back(16'h0040);
      run_group(0, 0);

      // CLR during DONE discards the result but OUT_DATA holds
      OUT_READY = 1'b0;
      repeat (8) feed(16'h0300, 0);
      chk("clr_done_valid", 32'(OUT_VALID), 32'd1);
      chk("clr_done_data", 32'(OUT_DATA), 32'h1800);
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      chk("clr_done_valid_fall", 32'(OUT_VALID), 32'd0);
      chk("clr_done_data_hold", 32'(OUT_DATA), 32'h1800);
      chk("clr_done_in_ready", 32'(IN_READY), 32'd1);

      // RST during DONE clears the pending (clipped) result
      repeat (8) feed(16'h1000, 0);
      chk("rst_done_valid", 32'(OUT_VALID), 32'd1);
      chk("rst_done_sat", 32'(OUT_SAT), 32'd1);
      chk("rst_done_data", 32'(OUT_DATA), 32'h7FFF);
      RST = 1'b1;
      tick();
      chk("rst_done_valid_fall", 32'(OUT_VALID), 32'd0);
      chk("rst_done_data_zero", 32'(OUT_DATA), 32'h0);
      chk("rst_done_sat_zero", 32'(OUT_SAT), 32'd0);
      chk("rst_done_in_ready", 32'(IN_READY), 32'd0);
      RST = 1'b0;
      #1;
      repeat (8) grp.push_back(16'h0040);
      run_group(0, 0);

      // Two-term instance: positive clip, then exact minimum
      run2(16'h7FFF, 16'h0001);
      run2(16'hC000, 16'hC000);
      for (int i = 0; i < 4; i++) run2(16'($urandom), 16'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
